// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the load-use hazard / forwarding controller.
// The datapath operand muxes decode the same FWD_* selects.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_EXE_ALU = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic       m2reg;
    logic [4:0] dest;
  } slot_t;

  // The nearest writer wins. A load still in EXE has no data yet, so it never forwards.
  function automatic logic [1:0] fwd_sel(logic exe_hit, logic exe_ld,
                                         logic mem_hit, logic mem_ld);
    logic [1:0] sel;
    sel = FWD_REG;
    if (exe_hit && !exe_ld) begin
      sel = FWD_EXE_ALU;
    end else if (mem_hit) begin
      sel = mem_ld ? FWD_MEM_LD : FWD_MEM_ALU;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage decode inputs and pipeline-control outputs of hazard_ctrl.
// The dbg_* signals expose the scoreboard slots.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  import hazard_ctrl_pkg::*;

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wreg;
  logic             id_m2reg;
  logic [4:0]       id_dest;
  logic             pc_we;
  logic             ifid_we;
  logic             idexe_bubble;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic [CNT_W-1:0] stall_cnt;
  slot_t            dbg_exe;
  slot_t            dbg_mem;
  slot_t            dbg_wb;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_dest,
    input  pc_we, ifid_we, idexe_bubble, fwda, fwdb, stall_cnt,
    input  dbg_exe, dbg_mem, dbg_wb
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_dest,
    output pc_we, ifid_we, idexe_bubble, fwda, fwdb, stall_cnt,
    output dbg_exe, dbg_mem, dbg_wb
  );

endinterface

// File: rtl/hazard_slot_match.sv
// Reports whether a scoreboard slot will write register i_reg. Register $0 never matches.
module hazard_slot_match
  import hazard_ctrl_pkg::*;
(
  input  slot_t      i_slot,
  input  logic [4:0] i_reg,
  output logic       o_writes
);

  assign o_writes = i_slot.valid && i_slot.wreg &&
                    (i_slot.dest == i_reg) && (i_reg != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Tracks the EXE/MEM/WB destinations to stall on a load-use hazard and to
// choose operand forwarding sources for the instruction in ID.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  slot_t            r_exe;
  slot_t            r_mem;
  slot_t            r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  slot_t w_id_slot;
  logic  w_exe_rs;
  logic  w_exe_rt;
  logic  w_mem_rs;
  logic  w_mem_rt;
  logic  w_stall;

  assign w_id_slot = '{valid: 1'b1, wreg: bus.id_wreg, m2reg: bus.id_m2reg,
                       dest: bus.id_dest};

  hazard_slot_match u_exe_rs (.i_slot(r_exe), .i_reg(bus.id_rs), .o_writes(w_exe_rs));
  hazard_slot_match u_exe_rt (.i_slot(r_exe), .i_reg(bus.id_rt), .o_writes(w_exe_rt));
  hazard_slot_match u_mem_rs (.i_slot(r_mem), .i_reg(bus.id_rs), .o_writes(w_mem_rs));
  hazard_slot_match u_mem_rt (.i_slot(r_mem), .i_reg(bus.id_rt), .o_writes(w_mem_rt));

  assign w_stall = r_exe.m2reg && ((w_exe_rs && bus.id_use_rs) ||
                                   (w_exe_rt && bus.id_use_rt));

  assign bus.pc_we        = !w_stall;
  assign bus.ifid_we      = !w_stall;
  assign bus.idexe_bubble = w_stall;
  assign bus.fwda         = fwd_sel(w_exe_rs, r_exe.m2reg, w_mem_rs, r_mem.m2reg);
  assign bus.fwdb         = fwd_sel(w_exe_rt, r_exe.m2reg, w_mem_rt, r_mem.m2reg);
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.dbg_exe      = r_exe;
  assign bus.dbg_mem      = r_mem;
  assign bus.dbg_wb       = r_wb;

  // WB is kept only to mirror MEM/WB; the register file covers that distance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exe <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_exe;
      r_exe <= w_stall ? slot_t'('0) : w_id_slot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, stall-counter width.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
REQ-005 id_use_rs, id_use_rt  in  1 each  the ID instruction reads rs / rt.
REQ-006 id_wreg, id_m2reg  in  1 each  ID decode: writes the register file / result comes from memory (load).
REQ-007 id_dest  in  5  ID destination register (the selected Rd/Rt).
REQ-008 pc_we  out  1  PC register write enable.
REQ-009 ifid_we  out  1  IF/ID register write enable.
REQ-010 idexe_bubble  out  1  forces ID/EXE control bits (wreg, m2reg, wmem) to zero this cycle.
REQ-011 fwda, fwdb  out  2 each  operand A/B source: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data.
REQ-012 stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-013 Internal scoreboard SHALL hold three slots (EXE, MEM, WB), each {valid, wreg, m2reg, dest}, mirroring the ID/EXE, EXE/MEM and MEM/WB pipeline registers.
REQ-014 Each rising edge: WB<=MEM, MEM<=EXE, and EXE<=ID fields with valid=1 when stall=0, or EXE<=all-zero (bubble) when stall=1.
REQ-015 A slot "writes r" only when valid=1, wreg=1, dest==r and r!=0; register $0 SHALL never cause forwarding or stall.
REQ-016 stall SHALL be 1 when the EXE slot has m2reg=1 and writes id_rs with id_use_rs=1, or writes id_rt with id_use_rt=1.
REQ-017 stall=1 SHALL give pc_we=0, ifid_we=0, idexe_bubble=1 in the same cycle (combinational); stall=0 SHALL give pc_we=1, ifid_we=1, idexe_bubble=0.
REQ-018 A load-use hazard SHALL cost exactly one stall cycle: after the bubble, the load is in MEM and the dependent instruction receives fwd=11.
REQ-019 fwda priority: EXE slot writes id_rs with m2reg=0 -> 01; else MEM slot writes id_rs -> 11 if MEM m2reg=1, else 10; else 00. fwdb identical on id_rt.
REQ-020 fwda/fwdb SHALL be driven from id_rs/id_rt regardless of the use flags; consumers ignore unused operands.
REQ-021 WB slot SHALL never produce forwarding; the register file writes in the first half of the cycle, so WB-distance reads are satisfied by the register file.
REQ-022 When stalled, fwda/fwdb still reflect the current (stalled) ID instruction; only the EXE-slot load is excluded from forwarding.
REQ-023 stall_cnt SHALL increment by 1 on every rising edge where stall=1 and SHALL hold at 2^CNT_W-1.
REQ-024 Back-to-back loads to the same register followed by a use SHALL stall once, on the nearer load only.

Reset
REQ-025 rst=1 SHALL clear all scoreboard slots and stall_cnt to 0 immediately, with no clock edge required.
REQ-026 During reset outputs SHALL be pc_we=1, ifid_we=1, idexe_bubble=0, fwda=fwdb=00.
REQ-027 Reset asserted mid-stall SHALL drop stall on assertion; the first edge after release SHALL load the ID instruction into EXE as a normal (non-bubble) entry.

Structure
REQ-028 A shared package SHALL define the fwd select encodings (FWD_REG, FWD_EXE_ALU, FWD_MEM_ALU, FWD_MEM_LD) and the scoreboard slot record; the datapath operand muxes SHALL use the same constants.
REQ-029 One sub-module SHALL be used: hazard_slot_match (slot, reg -> writes_r), instantiated once per slot/operand pair; everything else stays in hazard_ctrl.
REQ-030 hazard_ctrl SHALL sit beside ID in the cpu top level, driving PCRegister, IFIDRegister and IDEXERegister enables.

Verification
REQ-031 lw $2 then add $3,$2,$4 -> one cycle with pc_we=0, ifid_we=0, idexe_bubble=1; next cycle fwda=11, stall_cnt=1.
REQ-032 add $2,.. then sub $5,$2,$2 -> no stall, fwda=fwdb=01; one instruction later with a gap -> 10.
REQ-033 lw $0 then use of $0 -> no stall, fwda=00.
REQ-034 Same-register writer in EXE (ALU) and MEM (load) -> fwda=01 (nearest wins).
REQ-035 Assert rst during a stall cycle -> pc_we=1 immediately, stall_cnt=0; after release no bubble issued.
REQ-036 CNT_W=2, four consecutive load-use pairs -> stall_cnt reaches 3 and holds.
